multicycle_main_fsm: RTL and testbench

MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

---
 rtl/multicycle_main_fsm_pkg.sv | 64 ++++++
 rtl/multicycle_main_fsm.sv | 159 +++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_main_fsm_pkg.sv
// Shared definitions for the multicycle main control FSM: state encoding,
// opcode constants and the 2-bit datapath select encodings.
// Optional feature macro: MCFSM_JAL_EN (adds the JAL state and accepts op=111).
package multicycle_main_fsm_pkg;

    // Instruction opcodes (instr[6:0])
    localparam logic [6:0] OP_LW    = 7'd3;
    localparam logic [6:0] OP_SW    = 7'd35;
    localparam logic [6:0] OP_RTYPE = 7'd51;
    localparam logic [6:0] OP_ITYPE = 7'd19;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_BEQ   = 7'd99;

`ifdef MCFSM_JAL_EN
    localparam logic JAL_EN = 1'b1;
`else
    localparam logic JAL_EN = 1'b0;
`endif

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    // ALU decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // Controller states; the JAL encoding exists only when the feature is built
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
`ifdef MCFSM_JAL_EN
        S_JAL      = 4'd9,
`endif
        S_BEQ      = 4'd10
    } state_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW)    || (op == OP_SW)    ||
               (op == OP_RTYPE) || (op == OP_ITYPE) ||
               (op == OP_BEQ)   || ((op == OP_JAL) && JAL_EN);
    endfunction

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of a multicycle RISC-V style datapath.
// Outputs are decoded from the state register; only the FETCH strobes and the
// MEMWRITE completion (retire) look at mem_ready. All outputs are forced low
// while rst_n is asserted, so they drop asynchronously with the reset.
// Optional feature macro: MCFSM_JAL_EN (JAL state; without it op=111 is illegal).
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] res_src,
    output logic       illegal,
    output logic       retire
);

    state_t state_reg;

    // State register and transition logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:    if (mem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_RTYPE:     state_reg <= S_EXECR;
                        OP_ITYPE:     state_reg <= S_EXECI;
`ifdef MCFSM_JAL_EN
                        OP_JAL:       state_reg <= S_JAL;
`endif
                        OP_BEQ:       state_reg <= S_BEQ;
                        default:      state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    // op is stable, so anything other than lw/sw cannot arrive here
                    if (op == OP_LW)      state_reg <= S_MEMREAD;
                    else if (op == OP_SW) state_reg <= S_MEMWRITE;
                    else                  state_reg <= S_FETCH;
                end
                S_MEMREAD:  if (mem_ready) state_reg <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) state_reg <= S_FETCH;
                S_EXECR:    state_reg <= S_ALUWB;
                S_EXECI:    state_reg <= S_ALUWB;
`ifdef MCFSM_JAL_EN
                S_JAL:      state_reg <= S_ALUWB;
`endif
                S_MEMWB:    state_reg <= S_FETCH;
                S_ALUWB:    state_reg <= S_FETCH;
                S_BEQ:      state_reg <= S_FETCH;
                default:    state_reg <= S_FETCH;
            endcase
        end
    end

    // Moore output decode; everything defaults to 0 and stays 0 during reset
    always_comb begin
        adr_src   = 1'b0;
        ir_write  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALUOP_ADD;
        res_src   = RES_ALUOUT;
        illegal   = 1'b0;
        retire    = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    alu_op    = ALUOP_ADD;
                    res_src   = RES_ALURES;
                    ir_write  = mem_ready;
                    pc_update = mem_ready;
                end
                S_DECODE: begin
                    // Precompute the branch target while the opcode is decoded
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALUOP_ADD;
                    illegal   = !op_supported(op);
                end
                S_MEMADR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALUOP_ADD;
                end
                S_MEMREAD: begin
                    adr_src = 1'b1;
                    res_src = RES_ALUOUT;
                end
                S_MEMWB: begin
                    res_src   = RES_DATA;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    res_src   = RES_ALUOUT;
                    mem_write = 1'b1;
                    retire    = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    res_src   = RES_ALUOUT;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
`ifdef MCFSM_JAL_EN
                S_JAL: begin
                    // Link value old_pc+4 is computed; the target was formed in DECODE
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_FOUR;
                    alu_op    = ALUOP_ADD;
                    res_src   = RES_ALUOUT;
                    pc_update = 1'b1;
                end
`endif
                S_BEQ: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALUOP_SUB;
                    res_src   = RES_ALUOUT;
                    branch    = 1'b1;
                    retire    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed testbench for multicycle_main_fsm. Each step drives op/mem_ready
// in the low clock phase and compares the full packed output word.
// Output word: {adr_src, ir_write, pc_update, branch, reg_write, mem_write,
//               alu_src_a, alu_src_b, alu_op, res_src, illegal, retire}
module tb_multicycle_main_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       mem_ready;
    logic       adr_src, ir_write, pc_update, branch, reg_write, mem_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, res_src;
    logic       illegal, retire;

    int checks = 0;
    int errors = 0;

    multicycle_main_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .mem_ready (mem_ready),
        .adr_src   (adr_src),
        .ir_write  (ir_write),
        .pc_update (pc_update),
        .branch    (branch),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .res_src   (res_src),
        .illegal   (illegal),
        .retire    (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived output words per state          a  b  op res
    localparam logic [15:0] ZERO       = 16'b0_0_0_0_0_0_00_00_00_00_0_0;
    localparam logic [15:0] FETCH_RDY  = 16'b0_1_1_0_0_0_00_10_00_10_0_0;
    localparam logic [15:0] FETCH_WAIT = 16'b0_0_0_0_0_0_00_10_00_10_0_0;
    localparam logic [15:0] DECODE     = 16'b0_0_0_0_0_0_01_01_00_00_0_0;
    localparam logic [15:0] DECODE_ILL = 16'b0_0_0_0_0_0_01_01_00_00_1_0;
    localparam logic [15:0] MEMADR     = 16'b0_0_0_0_0_0_10_01_00_00_0_0;
    localparam logic [15:0] MEMREAD    = 16'b1_0_0_0_0_0_00_00_00_00_0_0;
    localparam logic [15:0] MEMWB      = 16'b0_0_0_0_1_0_00_00_00_01_0_1;
    localparam logic [15:0] MEMWR_WAIT = 16'b1_0_0_0_0_1_00_00_00_00_0_0;
    localparam logic [15:0] MEMWR_RDY  = 16'b1_0_0_0_0_1_00_00_00_00_0_1;
    localparam logic [15:0] EXECR      = 16'b0_0_0_0_0_0_10_00_10_00_0_0;
    localparam logic [15:0] EXECI      = 16'b0_0_0_0_0_0_10_01_10_00_0_0;
    localparam logic [15:0] ALUWB      = 16'b0_0_0_0_1_0_00_00_00_00_0_1;
    localparam logic [15:0] JALST      = 16'b0_0_1_0_0_0_01_10_00_00_0_0;
    localparam logic [15:0] BEQST      = 16'b0_0_0_1_0_0_10_00_01_00_0_1;

    function automatic logic [15:0] outs();
        return {adr_src, ir_write, pc_update, branch, reg_write, mem_write,
                alu_src_a, alu_src_b, alu_op, res_src, illegal, retire};
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = outs();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("t=%0t %-14s op=%0d rdy=%b outs=%b", $time, tag, op, mem_ready, obs);
    endtask

    // One clock cycle: drive inputs at the negedge, check 1ns later, advance
    task automatic cyc(input logic [6:0] o, input logic r, input logic [15:0] exp,
                       input string tag);
        op        = o;
        mem_ready = r;
        #1;
        check(tag, exp);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 7'd0;
        mem_ready = 1'b1;
        #1;
        check("rst_outs", ZERO);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_hold", ZERO);
        @(negedge clk);
        rst_n = 1'b1;

        // lw, no wait: 5 cycles
        cyc(7'd3, 1'b1, FETCH_RDY, "lw_fetch");
        cyc(7'd3, 1'b1, DECODE,    "lw_decode");
        cyc(7'd3, 1'b1, MEMADR,    "lw_memadr");
        cyc(7'd3, 1'b1, MEMREAD,   "lw_memread");
        cyc(7'd3, 1'b1, MEMWB,     "lw_memwb");

        // sw with two wait cycles in MEMWRITE
        cyc(7'd35, 1'b1, FETCH_RDY,  "sw_fetch");
        cyc(7'd35, 1'b1, DECODE,     "sw_decode");
        cyc(7'd35, 1'b1, MEMADR,     "sw_memadr");
        cyc(7'd35, 1'b0, MEMWR_WAIT, "sw_wait1");
        cyc(7'd35, 1'b0, MEMWR_WAIT, "sw_wait2");
        cyc(7'd35, 1'b1, MEMWR_RDY,  "sw_done");

        // R-type with fetch wait states
        cyc(7'd51, 1'b0, FETCH_WAIT, "r_fwait1");
        cyc(7'd51, 1'b0, FETCH_WAIT, "r_fwait2");
        cyc(7'd51, 1'b1, FETCH_RDY,  "r_fetch");
        cyc(7'd51, 1'b1, DECODE,     "r_decode");
        cyc(7'd51, 1'b1, EXECR,      "r_exec");
        cyc(7'd51, 1'b1, ALUWB,      "r_aluwb");

        // I-type
        cyc(7'd19, 1'b1, FETCH_RDY, "i_fetch");
        cyc(7'd19, 1'b1, DECODE,    "i_decode");
        cyc(7'd19, 1'b1, EXECI,     "i_exec");
        cyc(7'd19, 1'b1, ALUWB,     "i_aluwb");

        // beq: 3 cycles
        cyc(7'd99, 1'b1, FETCH_RDY, "beq_fetch");
        cyc(7'd99, 1'b1, DECODE,    "beq_decode");
        cyc(7'd99, 1'b1, BEQST,     "beq_beq");

        // unsupported opcode 0x7F
        cyc(7'h7F, 1'b1, FETCH_RDY,  "ill_fetch");
        cyc(7'h7F, 1'b1, DECODE_ILL, "ill_decode");

        // jal: full sequence when built in, illegal otherwise
        cyc(7'd111, 1'b1, FETCH_RDY, "jal_fetch");
`ifdef MCFSM_JAL_EN
        cyc(7'd111, 1'b1, DECODE,    "jal_decode");
        cyc(7'd111, 1'b1, JALST,     "jal_jal");
        cyc(7'd111, 1'b1, ALUWB,     "jal_aluwb");
`else
        cyc(7'd111, 1'b1, DECODE_ILL, "jal_illegal");
`endif

        // lw interrupted by reset while waiting in MEMREAD
        cyc(7'd3, 1'b1, FETCH_RDY, "rl_fetch");
        cyc(7'd3, 1'b1, DECODE,    "rl_decode");
        cyc(7'd3, 1'b1, MEMADR,    "rl_memadr");
        cyc(7'd3, 1'b0, MEMREAD,   "rl_memread1");
        op        = 7'd3;
        mem_ready = 1'b0;
        #1;
        check("rl_memread2", MEMREAD);
        #2;
        rst_n = 1'b0;
        #1;
        check("rl_async_rst", ZERO);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rl_rst_hold", ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(7'd3, 1'b1, FETCH_RDY, "rl_refetch");
        cyc(7'd3, 1'b1, DECODE,    "rl_redecode");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
